spike_aer_encoder: RTL and testbench

- Downstream stage of the PE array. Samples the N spike lines at each timestep boundary.
- Pulses spike_done back to the PEs so that spiking neurons reset their membrane potential.
- Serializes the captured spikes into address-event (AER) words over a valid/ready stream, lowest neuron index first.
- Each event is tagged with the current timestep number.

---
 rtl/snn_pkg.sv | 19 +
 rtl/lowest_set_idx.sv | 20 ++
 rtl/spike_aer_encoder.sv | 133 +++++++++++++
 tb/tb_spike_aer_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types for the spiking-network output path.
// Event layout, encoder states and default geometry.
package snn_pkg;

  localparam int N_NEURONS_DEF  = 16;
  localparam int TIMESTEP_W_DEF = 16;
  localparam int ADDR_W_DEF     = $clog2(N_NEURONS_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]     addr;
    logic [TIMESTEP_W_DEF-1:0] tstamp;
  } aer_event_t;

endpackage

// File: rtl/lowest_set_idx.sv
// Combinational priority finder: index of the lowest set bit.
// 'any' flags a non-empty vector; idx is 0 when vec is empty.
module lowest_set_idx #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     any
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = ($clog2(WIDTH))'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/spike_aer_encoder.sv
// Timestep sampler and AER serializer for the PE array spikes.
// Define SPIKE_STATS_EN to add spike_count / last_step_count.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter  int N_NEURONS  = N_NEURONS_DEF,
  parameter  int TIMESTEP_W = TIMESTEP_W_DEF,
  localparam int ADDR_W     = $clog2(N_NEURONS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step_valid,
  output logic                  step_ready,
  input  logic [N_NEURONS-1:0]  spike_in,
  output logic                  spike_done,
  output logic                  aer_valid,
  input  logic                  aer_ready,
  output logic [ADDR_W-1:0]     aer_addr,
  output logic [TIMESTEP_W-1:0] aer_time,
  output logic [TIMESTEP_W-1:0] timestep,
  output logic                  busy
`ifdef SPIKE_STATS_EN
  ,
  output logic [31:0]           spike_count,
  output logic [ADDR_W:0]       last_step_count
`endif
);

  enc_state_t            state_q, state_d;
  logic [N_NEURONS-1:0]  pending_q, pending_d;
  logic [TIMESTEP_W-1:0] cap_time_q, cap_time_d;
  logic [TIMESTEP_W-1:0] timestep_q, timestep_d;
  logic [ADDR_W-1:0]     low_idx;
  logic                  low_any;
  logic                  in_idle;
  logic                  step_fire;
  logic                  evt_fire;

  lowest_set_idx #(
    .WIDTH(N_NEURONS)
  ) u_lsi (
    .vec(pending_q),
    .idx(low_idx),
    .any(low_any)
  );

  assign in_idle   = (state_q == IDLE);
  assign step_fire = step_valid & in_idle;
  assign aer_valid = (state_q == SCAN) & low_any;
  assign evt_fire  = aer_valid & aer_ready;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cap_time_d = cap_time_q;
    timestep_d = timestep_q;
    unique case (state_q)
      IDLE: begin
        if (step_fire) begin
          pending_d  = spike_in;
          cap_time_d = timestep_q;
          timestep_d = timestep_q + TIMESTEP_W'(1);
          if (|spike_in) state_d = SCAN;
        end
      end
      SCAN: begin
        if (evt_fire) begin
          // x & (x-1) drops exactly the lowest set bit
          pending_d = pending_q & (pending_q - N_NEURONS'(1));
          if (pending_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      cap_time_q <= '0;
      timestep_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cap_time_q <= cap_time_d;
      timestep_q <= timestep_d;
    end
  end

  assign step_ready = in_idle;
  assign spike_done = step_fire;
  assign busy       = (state_q == SCAN);
  assign aer_addr   = low_idx;
  assign aer_time   = cap_time_q;
  assign timestep   = timestep_q;

`ifdef SPIKE_STATS_EN
  logic [31:0]   spike_count_q, spike_count_d;
  logic [ADDR_W:0] last_cnt_q, last_cnt_d;
  logic [ADDR_W:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      pop = pop + (ADDR_W + 1)'(spike_in[i]);
    end
  end

  always_comb begin
    spike_count_d = spike_count_q;
    last_cnt_d    = last_cnt_q;
    if (evt_fire && (spike_count_q != '1)) begin
      spike_count_d = spike_count_q + 32'd1;
    end
    if (step_fire) last_cnt_d = pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spike_count_q <= '0;
      last_cnt_q    <= '0;
    end else begin
      spike_count_q <= spike_count_d;
      last_cnt_q    <= last_cnt_d;
    end
  end

  assign spike_count     = spike_count_q;
  assign last_step_count = last_cnt_q;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder (16 neurons, 16-bit time).
// Expected events are queued at step fire; a monitor pops on handshake.
module tb_spike_aer_encoder;
  import snn_pkg::*;

  localparam int N  = 16;
  localparam int TW = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          step_valid;
  logic          step_ready;
  logic [N-1:0]  spike_in;
  logic          spike_done;
  logic          aer_valid;
  logic          aer_ready;
  logic [AW-1:0] aer_addr;
  logic [TW-1:0] aer_time;
  logic [TW-1:0] timestep;
  logic          busy;
`ifdef SPIKE_STATS_EN
  logic [31:0]   spike_count;
  logic [AW:0]   last_step_count;
`endif

  spike_aer_encoder #(
    .N_NEURONS(N),
    .TIMESTEP_W(TW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .spike_in(spike_in),
    .spike_done(spike_done),
    .aer_valid(aer_valid),
    .aer_ready(aer_ready),
    .aer_addr(aer_addr),
    .aer_time(aer_time),
    .timestep(timestep),
    .busy(busy)
`ifdef SPIKE_STATS_EN
    ,
    .spike_count(spike_count),
    .last_step_count(last_step_count)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          hs_m = 0;
  logic [TW-1:0] ts_m;
  aer_event_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    aer_event_t e;
    if (!reset && aer_valid && aer_ready) begin
      hs_m++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got addr %0d time %0h expected none",
                 aer_addr, aer_time);
      end else begin
        e = sb.pop_front();
        if (aer_addr !== e.addr || aer_time !== e.tstamp) begin
          errors++;
          $display("FAIL event: got addr %0d time %0h expected addr %0d time %0h",
                   aer_addr, aer_time, e.addr, e.tstamp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_step(input logic [N-1:0] v);
    aer_event_t e;
    bit ok;
    ok = 1'b0;
    step_valid = 1'b1;
    spike_in = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (step_ready) begin
        ok = 1'b1;
        break;
      end
      chk("no_done_while_busy", 32'(spike_done), 32'd0);
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got step_ready 0 expected 1");
    end else begin
      chk("spike_done", 32'(spike_done), 32'd1);
      for (int b = 0; b < N; b++) begin
        if (v[b]) begin
          e.addr = AW'(b);
          e.tstamp = ts_m;
          sb.push_back(e);
        end
      end
      ts_m = ts_m + TW'(1);
    end
    tick();
    step_valid = 1'b0;
    spike_in = ~v;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && step_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    step_valid = 1'b0;
    aer_ready = 1'b1;
    spike_in = '0;
    ts_m = '0;
    repeat (3) tick();
    @(negedge clock);
    chk("rst_aer_valid", 32'(aer_valid), 32'd0);
    chk("rst_timestep", 32'(timestep), 32'd0);
    chk("rst_step_ready", 32'(step_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_aer_addr", 32'(aer_addr), 32'd0);
    chk("rst_aer_time", 32'(aer_time), 32'd0);
    tick();
    reset = 1'b0;

    // empty step
    do_step(16'h0000);
    @(negedge clock);
    chk("empty_timestep", 32'(timestep), 32'd1);
    chk("empty_no_valid", 32'(aer_valid), 32'd0);
    chk("empty_idle", 32'(step_ready), 32'd1);
    tick();

    // four events back to back
    do_step(16'h8421);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_not_ready", 32'(step_ready), 32'd0);
      tick();
    end
    @(negedge clock);
    chk("ready_5th_cycle", 32'(step_ready), 32'd1);
    chk("idle_no_valid", 32'(aer_valid), 32'd0);
    chk("sb_empty_8421", 32'(sb.size()), 32'd0);
    tick();

    // backpressure holds the word
    aer_ready = 1'b0;
    do_step(16'h0003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_valid", 32'(aer_valid), 32'd1);
      chk("hold_addr", 32'(aer_addr), 32'd0);
      chk("hold_time", 32'(aer_time), 32'd2);
      tick();
    end
    aer_ready = 1'b1;
    drain();
    chk("sb_empty_0003", 32'(sb.size()), 32'd0);

    // step_valid held through SCAN
    do_step(16'h00F0);
    do_step(16'h0101);
    drain();
    @(negedge clock);
    chk("held_step_ts", 32'(timestep), 32'd5);
    tick();

    // reset mid-scan after two events
    do_step(16'h000F);
    @(negedge clock);
    tick();
    @(negedge clock);
    tick();
    reset = 1'b1;
    aer_ready = 1'b0;
    tick();
    @(negedge clock);
    chk("midrst_valid", 32'(aer_valid), 32'd0);
    chk("midrst_timestep", 32'(timestep), 32'd0);
    chk("midrst_ready", 32'(step_ready), 32'd1);
    chk("midrst_left", 32'(sb.size()), 32'd2);
    sb.delete();
    ts_m = '0;
    hs_m = 0;
    tick();
    reset = 1'b0;
    aer_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_quiet", 32'(aer_valid), 32'd0);
      tick();
    end

    // timestep wrap
    step_valid = 1'b1;
    spike_in = '0;
    repeat (65535) tick();
    step_valid = 1'b0;
    ts_m = 16'hFFFF;
    @(negedge clock);
    chk("preload_ts", 32'(timestep), 32'hFFFF);
    tick();
    do_step(16'h0001);
    drain();
    @(negedge clock);
    chk("wrap_ts", 32'(timestep), 32'd0);
    chk("wrap_events", 32'(hs_m), 32'd1);
`ifdef SPIKE_STATS_EN
    chk("spike_count", spike_count, 32'd1);
    chk("last_step_count", 32'(last_step_count), 32'd1);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
